multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Main control FSM of the multicycle RV32I core; sits upstream of the immediate extender and drives its ImmSrc select.
- Decodes the instruction register fields and generates datapath selects and write enables, one FSM state per cycle.
- Write enables (PC/IR/Mem/Reg) are Moore outputs; PCWrite is Mealy on the branch flags.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH); must be a legal state code.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- Op  input  7  instr[6:0]
- Funct3  input  3  instr[14:12]
- Funct7b5  input  1  instr[30]
- Zero  input  1  ALU result == 0
- Lt  input  1  signed less-than flag of ALU subtraction
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address: 0 = PC, 1 = Result
- MemWrite  output  1  data memory write enable
- IRWrite  output  1  instruction/OldPC register enable
- RegWrite  output  1  register-file write enable
- ResultSrc  output  2  00 ALUOut, 01 ReadData, 10 ALUResult, 11 ImmExt
- ALUSrcA  output  2  00 PC, 01 OldPC, 10 RD1
- ALUSrcB  output  2  00 RD2, 01 ImmExt, 10 constant 4
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
- ImmSrc  output  3  000 I, 001 S, 010 B, 011 J, 100 U (extender encoding)
- Illegal  output  1  sticky illegal-opcode flag (feature only; else tied 0)

Behaviour:
- State register is 4 bits. States: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, LUI 12, HALT 13.
- Reset: rst low -> state = FETCH asynchronously.
  - While rst is low, PCWrite, IRWrite, MemWrite and RegWrite are forced 0.
  - Illegal = 0. All other outputs take their FETCH values.
  - Deasserting rst mid-instruction restarts at FETCH.
- Defaults for every output not listed in a state: 0.
- FETCH: AdrSrc 0, IRWrite 1, ALUSrcA 00, ALUSrcB 10, add, ResultSrc 10, PCWrite 1 -> DECODE.
- DECODE: ALUSrcA 01, ALUSrcB 01, add (ALUOut <= branch/JAL target). Next state by Op:
  - 0000011 / 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - other -> FETCH
- MEMADR: ALUSrcA 10, ALUSrcB 01, add. Next: MEMREAD for load, MEMWRITE for store.
- MEMREAD: ResultSrc 00, AdrSrc 1 -> MEMWB.
- MEMWB: ResultSrc 01, RegWrite 1 -> FETCH.
- MEMWRITE: ResultSrc 00, AdrSrc 1, MemWrite 1 -> FETCH.
- EXECR: ALUSrcA 10, ALUSrcB 00 -> ALUWB.
- EXECI: ALUSrcA 10, ALUSrcB 01 -> ALUWB.
- ALUWB: ResultSrc 00, RegWrite 1 -> FETCH.
- BRANCH: ALUSrcA 10, ALUSrcB 00, sub, ResultSrc 00 -> FETCH.
  - PCWrite = taken. Taken by Funct3: 000 Zero, 001 ~Zero, 100 Lt, 101 ~Lt, others 0.
- JAL: ALUSrcA 01, ALUSrcB 10, add, ResultSrc 00, PCWrite 1 -> ALUWB (rd <= OldPC+4).
- JALR: ALUSrcA 10, ALUSrcB 01, add (ALUOut <= rs1+imm) -> JAL.
- LUI: ResultSrc 11, RegWrite 1 -> FETCH.
- ImmSrc is decoded from Op in every state: load/I-ALU/JALR 000, store 001, branch 010, JAL 011, LUI 100, else 000.
- ALUControl in EXECR/EXECI by Funct3:
  - 000: sub only if EXECR and Funct7b5 = 1, else add
  - 010 slt, 100 xor, 110 or, 111 and, other add
- Latencies in cycles: load 5, store 4, R/I 4, branch 3, JAL 4, JALR 5, LUI 3.

Optional Feature:
- Macro MC_ILLEGAL_TRAP_EN.
- Defined: unknown Op in DECODE -> HALT and Illegal <= 1. HALT holds with all enables 0 until reset.
- Undefined: unknown Op -> FETCH (instruction skipped); HALT unreachable; Illegal constant 0.

Test Plan:
- Reset pulse low mid-MEMADR -> state FETCH immediately; all write enables 0 while rst low; after release, IRWrite = 1 and PCWrite = 1 on first cycle.
- Op 0000011 (lw) -> states 0,1,2,3,4; RegWrite = 1 only in cycle 5 with ResultSrc 01; ImmSrc 000 throughout.
- Op 0100011 (sw) -> states 0,1,2,5; MemWrite = 1 only in cycle 4 with AdrSrc 1; ImmSrc 001.
- Op 1100011, Funct3 001: Zero = 0 -> PCWrite 1 in BRANCH; Zero = 1 -> PCWrite 0; ALUControl 001; ImmSrc 010.
- Op 0110011, Funct3 000, Funct7b5 1 -> ALUControl 001 in EXECR; Funct7b5 0 -> 000; Op 0010011 with Funct7b5 1 -> 000.
- Op 1100111 (jalr) -> states 0,1,11,10,8; PCWrite 1 in JAL; Op 1111111 -> FETCH (or HALT with Illegal = 1 under MC_ILLEGAL_TRAP_EN).

Source files
------------

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core.
// Optional illegal-opcode trap: define MC_ILLEGAL_TRAP_EN.
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic [2:0] Funct3,
  input  logic       Funct7b5,
  input  logic       Zero,
  input  logic       Lt,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       Illegal
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    LUI      = 4'd12,
    HALT     = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t state, next;
  logic   pcw, irw, mw, rw, taken;

  function automatic logic [2:0] alu_dec(
    input logic [2:0] f3,
    input logic       sub
  );
    logic [2:0] r;
    r = ALU_ADD;
    case (f3)
      3'b000:  r = sub ? ALU_SUB : ALU_ADD;
      3'b010:  r = ALU_SLT;
      3'b100:  r = ALU_XOR;
      3'b110:  r = ALU_OR;
      3'b111:  r = ALU_AND;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= state_t'(RESET_STATE);
    else      state <= next;
  end

  always_comb begin
    taken = 1'b0;
    case (Funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      3'b100:  taken = Lt;
      3'b101:  taken = ~Lt;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    ImmSrc = 3'b000;
    unique case (1'b1)
      Op == OP_STORE: ImmSrc = 3'b001;
      Op == OP_BR:    ImmSrc = 3'b010;
      Op == OP_JAL:   ImmSrc = 3'b011;
      Op == OP_LUI:   ImmSrc = 3'b100;
      default:        ImmSrc = 3'b000;
    endcase
  end

  always_comb begin
    next       = FETCH;
    pcw        = 1'b0;
    irw        = 1'b0;
    mw         = 1'b0;
    rw         = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    unique case (state)
      FETCH: begin
        irw       = 1'b1;
        pcw       = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        next      = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (Op)
          OP_LOAD,
          OP_STORE: next = MEMADR;
          OP_R:     next = EXECR;
          OP_I:     next = EXECI;
          OP_BR:    next = BRANCH;
          OP_JAL:   next = JAL;
          OP_JALR:  next = JALR;
          OP_LUI:   next = LUI;
`ifdef MC_ILLEGAL_TRAP_EN
          default:  next = HALT;
`else
          default:  next = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        next    = (Op == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        next   = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        rw        = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mw     = 1'b1;
      end
      EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_dec(Funct3, Funct7b5);
        next       = ALUWB;
      end
      EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec(Funct3, 1'b0);
        next       = ALUWB;
      end
      ALUWB: rw = 1'b1;
      BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        pcw        = taken;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pcw     = 1'b1;
        next    = ALUWB;
      end
      JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        next    = JAL;
      end
      LUI: begin
        ResultSrc = 2'b11;
        rw        = 1'b1;
      end
      HALT: next = HALT;
      default: next = FETCH;
    endcase
  end

  // enables are gated so nothing commits while reset is held
  assign PCWrite  = pcw & rst;
  assign IRWrite  = irw & rst;
  assign MemWrite = mw & rst;
  assign RegWrite = rw & rst;

`ifdef MC_ILLEGAL_TRAP_EN
  logic ill_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            ill_q <= 1'b0;
    else if (state == DECODE && next == HALT) ill_q <= 1'b1;
  end

  assign Illegal = ill_q;
`else
  assign Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller.
// Expected outputs come from a per-instruction cycle model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] Op;
  logic [2:0] Funct3;
  logic       Funct7b5, Zero, Lt;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;
  logic       Illegal;

  int nchk = 0;
  int nerr = 0;

  localparam logic [16:0] EN_MASK = 17'b1_0111_0000_0000_0000;

  logic [6:0] legal [8] = '{7'b0000011, 7'b0100011, 7'b0110011,
                            7'b0010011, 7'b1100011, 7'b1101111,
                            7'b1100111, 7'b0110111};

  multicycle_controller dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct3(Funct3),
    .Funct7b5(Funct7b5), .Zero(Zero), .Lt(Lt),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] obs();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
            ALUSrcA, ALUSrcB, ALUControl, ImmSrc};
  endfunction

  function automatic int latency(input logic [6:0] op);
    case (op)
      7'b0000011: return 5;
      7'b0100011: return 4;
      7'b0110011: return 4;
      7'b0010011: return 4;
      7'b1100011: return 3;
      7'b1101111: return 4;
      7'b1100111: return 5;
      7'b0110111: return 3;
      default:    return 2;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      7'b0100011: return 3'd1;
      7'b1100011: return 3'd2;
      7'b1101111: return 3'd3;
      7'b0110111: return 3'd4;
      default:    return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [2:0] f3,
                                        input logic sub);
    case (f3)
      3'b000:  return sub ? 3'd1 : 3'd0;
      3'b010:  return 3'd5;
      3'b100:  return 3'd4;
      3'b110:  return 3'd3;
      3'b111:  return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  // Expected outputs for cycle k of an instruction
  function automatic logic [16:0] expv(input logic [6:0] op,
    input logic [2:0] f3, input logic f7, input logic z,
    input logic lt, input int k);
    logic pcw, adr, mw, irw, rw, tk;
    logic [1:0] rs, sa, sb;
    logic [2:0] alu;
    {pcw, adr, mw, irw, rw} = '0;
    rs = 0; sa = 0; sb = 0; alu = 0;
    tk = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z :
         (f3 == 3'b100) ? lt : (f3 == 3'b101) ? !lt : 1'b0;
    if (k == 0) begin
      pcw = 1; irw = 1; sb = 2; rs = 2;
    end else if (k == 1) begin
      sa = 1; sb = 1;
    end else begin
      case (op)
        7'b0000011: case (k)
          2: begin sa = 2; sb = 1; end
          3: adr = 1;
          default: begin rs = 1; rw = 1; end
        endcase
        7'b0100011: if (k == 2) begin sa = 2; sb = 1; end
                    else begin adr = 1; mw = 1; end
        7'b0110011: if (k == 2) begin sa = 2; alu = alu_of(f3, f7); end
                    else rw = 1;
        7'b0010011: if (k == 2) begin
                      sa = 2; sb = 1; alu = alu_of(f3, 1'b0);
                    end else rw = 1;
        7'b1100011: begin sa = 2; alu = 1; pcw = tk; end
        7'b1101111: if (k == 2) begin sa = 1; sb = 2; pcw = 1; end
                    else rw = 1;
        7'b1100111: case (k)
          2: begin sa = 2; sb = 1; end
          3: begin sa = 1; sb = 2; pcw = 1; end
          default: rw = 1;
        endcase
        7'b0110111: begin rs = 3; rw = 1; end
        default: ;
      endcase
    end
    return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm_of(op)};
  endfunction

  // Entered just after a posedge with the DUT in FETCH
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input int ncyc);
    int n;
    n = latency(op);
    if (ncyc < n) n = ncyc;
    Op = op; Funct3 = f3; Funct7b5 = f7;
    for (int k = 0; k < n; k++) begin
      Zero = 1'($urandom); Lt = 1'($urandom);
      @(negedge clk);
      check($sformatf("op%b f3%b k%0d", op, f3, k), 32'(obs()),
            32'(expv(op, f3, f7, Zero, Lt, k)));
      check("illegal", 32'(Illegal), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [6:0] op;
    int         idx, hi;
    rst = 0; Op = 7'b0000011; Funct3 = 0; Funct7b5 = 0;
    Zero = 0; Lt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_en", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'd0);
    check("rst_out", 32'(obs()),
          32'(expv(Op, 3'd0, 1'b0, 1'b0, 1'b0, 0) & ~EN_MASK));
    check("rst_ill", 32'(Illegal), 32'd0);
    @(posedge clk); #1;
    rst = 1;
    run_instr(7'b0000011, 3'd2, 1'b0, 99);
    // reset pulse while in MEMADR
    run_instr(7'b0000011, 3'd2, 1'b0, 2);
    #2 rst = 0;
    #1;
    check("midrst_out", 32'(obs()),
          32'(expv(Op, 3'd2, 1'b0, Zero, Lt, 0) & ~EN_MASK));
    @(negedge clk);
    check("midrst_en", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'd0);
    @(posedge clk); #1;
    rst = 1;
    run_instr(7'b0000011, 3'd2, 1'b0, 99);
    run_instr(7'b0100011, 3'd2, 1'b0, 99);
    run_instr(7'b0110011, 3'd0, 1'b1, 99);
    run_instr(7'b0110011, 3'd0, 1'b0, 99);
    run_instr(7'b0010011, 3'd0, 1'b1, 99);
    run_instr(7'b1100011, 3'd1, 1'b0, 99);
    run_instr(7'b1100111, 3'd0, 1'b0, 99);
`ifdef MC_ILLEGAL_TRAP_EN
    hi = 7;
`else
    hi = 8;
    run_instr(7'b1111111, 3'd0, 1'b0, 99);
`endif
    for (int i = 0; i < 400; i++) begin
      idx = $urandom_range(0, hi);
      if (idx < 8) op = legal[idx];
      else begin
        op = 7'($urandom);
        while (latency(op) != 2) op = 7'($urandom);
      end
      run_instr(op, 3'($urandom), 1'($urandom), 99);
    end
`ifdef MC_ILLEGAL_TRAP_EN
    run_instr(7'b1111111, 3'd0, 1'b0, 99);
    repeat (3) begin
      @(negedge clk);
      check("halt_out", 32'(obs()), 32'd0);
      check("halt_ill", 32'(Illegal), 32'd1);
    end
    @(posedge clk); #1;
    rst = 0;
    #1 check("halt_rst_ill", 32'(Illegal), 32'd0);
    @(posedge clk); #1;
    rst = 1;
    run_instr(7'b0110111, 3'd0, 1'b0, 99);
`endif
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
